// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types, constants and helpers for the Ethernet frame buffer
// Optional feature macro: FRAME_HDR_EN (see eth_frame_buf.sv)
package eth_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W      = 16;

    // Magic value placed in the upper half of the optional frame header word.
    localparam logic [15:0] HDR_MAGIC = 16'hA55A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturating increment for the error counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/eth_frame_ram.sv
// rtl/eth_frame_ram.sv - simple dual-port frame RAM with registered read
// Ports: clk, reset (sync, active-high, clears only the read register),
//        wr_en/wr_addr/wr_data write port, rd_addr/rd_data read port (1-cycle latency).
module eth_frame_ram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // Storage array is kept out of the reset path so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_frame_buf.sv
// rtl/eth_frame_buf.sv - ping-pong acquisition frame buffer feeding the Ethernet sender
// Ports: clk, reset (sync, active-high); acquisition side i_sync/i_data/i_vld;
//        sender side i_rd_busy/i_rd_addr/o_rd_data/o_msync_n; status o_frame_seq,
//        o_drop_cnt, o_short_cnt, o_wr_bank.
// Optional feature macro: FRAME_HDR_EN - word 0 of each frame carries {HDR_MAGIC, frame_seq}.
module eth_frame_buf
    import eth_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int FRAME_WORDS = 1024,
    parameter int MSYNC_LEN   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_sync,
    input  logic [31:0]       i_data,
    input  logic              i_vld,
    input  logic              i_rd_busy,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_data,
    output logic              o_msync_n,
    output logic [CNT_W-1:0]  o_frame_seq,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic [CNT_W-1:0]  o_short_cnt,
    output logic              o_wr_bank
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_WORDS - 1);
`ifdef FRAME_HDR_EN
    localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_PTR = '0;
`endif

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   wr_ptr, ptr_nxt;
    logic                sync_pend, pend_nxt;
    logic                rd_bank, rd_bank_nxt, wr_bank_nxt;
    logic [7:0]          ms_cnt, ms_nxt;
    logic [CNT_W-1:0]    seq_nxt, drop_nxt, short_nxt;
    logic                start;
    logic                we;
    logic                w_bank;
    logic [ADDR_W-1:0]   w_ptr;
    logic [31:0]         w_data;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = wr_ptr;
        pend_nxt    = sync_pend;
        rd_bank_nxt = rd_bank;
        wr_bank_nxt = o_wr_bank;
        seq_nxt     = o_frame_seq;
        drop_nxt    = o_drop_cnt;
        short_nxt   = o_short_cnt;
        ms_nxt      = (ms_cnt != 8'd0) ? ms_cnt - 8'd1 : 8'd0;
        start       = 1'b0;
        we          = 1'b0;
        w_bank      = o_wr_bank;
        w_ptr       = wr_ptr;
        w_data      = i_data;

        case (state)
            IDLE: begin
                if (i_sync || sync_pend) begin
                    start = 1'b1;
                end
            end
            FILL: begin
                if (i_vld && wr_ptr == LAST_PTR) begin
                    // Final word wins over a coincident sync; the sync is remembered.
                    we        = 1'b1;
                    state_nxt = DONE;
                    if (i_sync) begin
                        pend_nxt = 1'b1;
                    end
                end else if (i_sync) begin
                    ptr_nxt   = FIRST_PTR;
                    short_nxt = sat_inc(o_short_cnt);
                end else if (i_vld) begin
                    we      = 1'b1;
                    ptr_nxt = wr_ptr + 1'b1;
                end
            end
            DONE: begin
                if (!i_rd_busy) begin
                    rd_bank_nxt = o_wr_bank;
                    wr_bank_nxt = ~o_wr_bank;
                    seq_nxt     = o_frame_seq + 1'b1;
                    ms_nxt      = 8'(MSYNC_LEN);
                end else begin
                    drop_nxt = sat_inc(o_drop_cnt);
                end
                if (i_sync || sync_pend) begin
                    start = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start) begin
            state_nxt = FILL;
            ptr_nxt   = FIRST_PTR;
            pend_nxt  = 1'b0;
`ifdef FRAME_HDR_EN
            // Header goes into the bank the new frame will occupy, tagged with the
            // sequence number as it stands once any concurrent publish has landed.
            we     = 1'b1;
            w_bank = wr_bank_nxt;
            w_ptr  = '0;
            w_data = {HDR_MAGIC, seq_nxt};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            sync_pend   <= 1'b0;
            rd_bank     <= 1'b1;
            o_wr_bank   <= 1'b0;
            ms_cnt      <= 8'd0;
            o_msync_n   <= 1'b1;
            o_frame_seq <= '0;
            o_drop_cnt  <= '0;
            o_short_cnt <= '0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= ptr_nxt;
            sync_pend   <= pend_nxt;
            rd_bank     <= rd_bank_nxt;
            o_wr_bank   <= wr_bank_nxt;
            ms_cnt      <= ms_nxt;
            o_msync_n   <= (ms_nxt == 8'd0);
            o_frame_seq <= seq_nxt;
            o_drop_cnt  <= drop_nxt;
            o_short_cnt <= short_nxt;
        end
    end

    eth_frame_ram #(
        .AW (ADDR_W + 1),
        .DW (32)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (we & ~reset),
        .wr_addr ({w_bank, w_ptr}),
        .wr_data (w_data),
        .rd_addr ({rd_bank, i_rd_addr}),
        .rd_data (o_rd_data)
    );

endmodule

// File: tb/tb_eth_frame_buf.sv
// tb/tb_eth_frame_buf.sv - self-checking bench for eth_frame_buf
module tb_eth_frame_buf;

`ifdef FRAME_HDR_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif
    localparam int FW = 1024;
    localparam int NW = FW - OFS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_sync = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_vld = 1'b0;
    logic        i_rd_busy = 1'b0;
    logic [9:0]  i_rd_addr = '0;
    logic [31:0] o_rd_data;
    logic        o_msync_n;
    logic [15:0] o_frame_seq;
    logic [15:0] o_drop_cnt;
    logic [15:0] o_short_cnt;
    logic        o_wr_bank;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[6];

    eth_frame_buf dut (
        .clk         (clk),
        .reset       (reset),
        .i_sync      (i_sync),
        .i_data      (i_data),
        .i_vld       (i_vld),
        .i_rd_busy   (i_rd_busy),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_msync_n   (o_msync_n),
        .o_frame_seq (o_frame_seq),
        .o_drop_cnt  (o_drop_cnt),
        .o_short_cnt (o_short_cnt),
        .o_wr_bank   (o_wr_bank)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] base, input int a);
        return base + 32'(a) - 32'(OFS);
    endfunction

    task automatic send_words(input logic [31:0] base, input int n, input bit sync_last);
        for (int i = 0; i < n; i++) begin
            i_vld  = 1'b1;
            i_data = base + 32'(i);
            i_sync = (sync_last && i == n - 1);
            tick();
        end
        i_vld  = 1'b0;
        i_sync = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int n, input bit sync_last);
        i_sync = 1'b1;
        tick();
        i_sync = 1'b0;
        send_words(base, n, sync_last);
    endtask

    // Call right after the last-word cycle; reports first low cycle and low length.
    task automatic measure_strobe(output int first, output int len);
        first = -1;
        len   = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (!o_msync_n) begin
                if (first < 0) first = k;
                len++;
            end
        end
    endtask

    task automatic rd_check(input string name, input int addr, input logic [31:0] exp);
        i_rd_addr = 10'(addr);
        tick();
        check(name, o_rd_data, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int first, len;

        // Reset state
        do_reset();
        check("rst_msync_n", 32'(o_msync_n), 32'd1);
        check("rst_seq", 32'(o_frame_seq), 32'd0);
        check("rst_drop", 32'(o_drop_cnt), 32'd0);
        check("rst_short", 32'(o_short_cnt), 32'd0);
        check("rst_wr_bank", 32'(o_wr_bank), 32'd0);
        check("rst_rd_data", o_rd_data, 32'd0);

        // Nominal frame; i_vld while IDLE must be ignored
        i_vld = 1'b1; i_data = 32'hDEAD_BEEF;
        tick();
        i_vld = 1'b0;
        send_frame(32'h0, NW, 1'b0);
        check("nom_done_bank_hold", 32'(o_wr_bank), 32'd0);
        check("nom_done_msync_hi", 32'(o_msync_n), 32'd1);
        measure_strobe(first, len);
        check("nom_strobe_first", 32'(first), 32'd1);
        check("nom_strobe_len", 32'(len), 32'd4);
        check("nom_seq", 32'(o_frame_seq), 32'd1);
        check("nom_wr_bank", 32'(o_wr_bank), 32'd1);
        vecs[0] = '{5, exp_word(32'h0, 5)};
        vecs[1] = '{OFS, 32'h0};
        vecs[2] = '{OFS + 1, 32'h1};
        vecs[3] = '{511, exp_word(32'h0, 511)};
        vecs[4] = '{1022, exp_word(32'h0, 1022)};
        vecs[5] = '{1023, exp_word(32'h0, 1023)};
        for (int k = 0; k < 6; k++) begin
            rd_check($sformatf("nom_rd[%0d]", k), vecs[k].addr, vecs[k].exp);
        end

        // Busy drop, then a publish with busy released
        i_rd_busy = 1'b1;
        send_frame(32'h1000_0000, NW, 1'b0);
        measure_strobe(first, len);
        check("busy_strobe_len", 32'(len), 32'd0);
        check("busy_drop", 32'(o_drop_cnt), 32'd1);
        check("busy_seq", 32'(o_frame_seq), 32'd1);
        check("busy_wr_bank", 32'(o_wr_bank), 32'd1);
        rd_check("busy_rd5", 5, exp_word(32'h0, 5));
        i_rd_busy = 1'b0;
        send_frame(32'h2000_0000, NW, 1'b0);
        measure_strobe(first, len);
        check("pub2_strobe_len", 32'(len), 32'd4);
        check("pub2_seq", 32'(o_frame_seq), 32'd2);
        check("pub2_wr_bank", 32'(o_wr_bank), 32'd0);
        rd_check("pub2_rd5", 5, exp_word(32'h2000_0000, 5));

        // Short frame aborted by an early sync
        send_frame(32'h3000_0000, 300, 1'b0);
        send_frame(32'h4000_0000, NW, 1'b0);
        measure_strobe(first, len);
        check("short_cnt", 32'(o_short_cnt), 32'd1);
        check("short_seq", 32'(o_frame_seq), 32'd3);
        rd_check("short_rd_first", OFS, 32'h4000_0000);
        rd_check("short_rd299", 299, exp_word(32'h4000_0000, 299));

        // Sync coincident with the last word: next frame needs no extra sync
        send_frame(32'h5000_0000, NW, 1'b1);
        measure_strobe(first, len);
        check("coin_strobe_len", 32'(len), 32'd4);
        check("coin_seq", 32'(o_frame_seq), 32'd4);
        check("coin_short", 32'(o_short_cnt), 32'd1);
        rd_check("coin_rd7", 7, exp_word(32'h5000_0000, 7));
        send_words(32'h6000_0000, NW, 1'b0);
        measure_strobe(first, len);
        check("coin_next_seq", 32'(o_frame_seq), 32'd5);
        rd_check("coin_next_rd_first", OFS, 32'h6000_0000);
        rd_check("coin_next_rd1023", 1023, exp_word(32'h6000_0000, 1023));

        // Reset in the middle of a fill
        send_frame(32'h7700_0000, 500, 1'b0);
        do_reset();
        measure_strobe(first, len);
        check("midrst_strobe_len", 32'(len), 32'd0);
        check("midrst_wr_bank", 32'(o_wr_bank), 32'd0);
        send_frame(32'h7000_0000, NW, 1'b0);
        measure_strobe(first, len);
        check("midrst_strobe_after", 32'(len), 32'd4);
        check("midrst_seq", 32'(o_frame_seq), 32'd1);
        check("midrst_short", 32'(o_short_cnt), 32'd0);
        check("midrst_bank", 32'(o_wr_bank), 32'd1);
        rd_check("midrst_rd7", 7, exp_word(32'h7000_0000, 7));

`ifdef FRAME_HDR_EN
        // Header word on the second published frame after reset
        do_reset();
        send_frame(32'h8000_0000, NW, 1'b0);
        measure_strobe(first, len);
        rd_check("hdr_rd0_first", 0, 32'hA55A_0000);
        send_frame(32'h9000_0000, NW, 1'b0);
        measure_strobe(first, len);
        rd_check("hdr_rd0", 0, 32'hA55A_0001);
        rd_check("hdr_rd1", 1, 32'h9000_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
